// File: rtl/mc_maindec.sv
// Multicycle MIPS main controller: fetch/decode/execute/memory/writeback FSM.
// Optional `j` support is compiled in when MC_MAINDEC_JUMP_EN is defined.
module mc_maindec (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic       memready,
    output logic       iord,
    output logic       memwrite,
    output logic       irwrite,
    output logic       pcwrite,
    output logic       branch,
    output logic [1:0] pcsrc,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] aluop,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       illegal
);

    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_RT   = 6'b000000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
`ifdef MC_MAINDEC_JUMP_EN
    localparam logic [5:0] OP_J    = 6'b000010;
`endif

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        MEMADR,
        MEMRD,
        MEMWB,
        MEMWR,
        RTYPEEX,
        RTYPEWB,
        BEQEX,
        ADDIEX,
        ADDIWB,
`ifdef MC_MAINDEC_JUMP_EN
        JEX,
`endif
        ERROR
    } state_t;

    state_t state;
    state_t next;

    // State register; reset restarts at instruction fetch.
    always_ff @(posedge clk) begin
        if (reset) state <= FETCH;
        else       state <= next;
    end

    // Next-state logic; memory states hold until memready.
    always_comb begin
        next = state;
        unique case (state)
            FETCH:   if (memready) next = DECODE;
            DECODE: begin
                unique case (op)
                    OP_LW, OP_SW: next = MEMADR;
                    OP_RT:        next = RTYPEEX;
                    OP_BEQ:       next = BEQEX;
                    OP_ADDI:      next = ADDIEX;
`ifdef MC_MAINDEC_JUMP_EN
                    OP_J:         next = JEX;
`endif
                    default:      next = ERROR;
                endcase
            end
            MEMADR:  next = (op == OP_SW) ? MEMWR : MEMRD;
            MEMRD:   if (memready) next = MEMWB;
            MEMWR:   if (memready) next = FETCH;
            RTYPEEX: next = RTYPEWB;
            ADDIEX:  next = ADDIWB;
            MEMWB, RTYPEWB, ADDIWB, BEQEX:
                     next = FETCH;
`ifdef MC_MAINDEC_JUMP_EN
            JEX:     next = FETCH;
`endif
            ERROR:   next = ERROR;
            default: next = FETCH;
        endcase
    end

    // Output decode; everything is forced low while reset is asserted.
    always_comb begin
        iord     = 1'b0;
        memwrite = 1'b0;
        irwrite  = 1'b0;
        pcwrite  = 1'b0;
        branch   = 1'b0;
        pcsrc    = 2'b00;
        alusrca  = 1'b0;
        alusrcb  = 2'b00;
        aluop    = 2'b00;
        regdst   = 1'b0;
        memtoreg = 1'b0;
        regwrite = 1'b0;
        illegal  = 1'b0;
        if (!reset) begin
            unique case (state)
                FETCH: begin
                    alusrcb = 2'b01;
                    irwrite = memready;
                    pcwrite = memready;
                end
                DECODE:  alusrcb = 2'b11;
                MEMADR: begin
                    alusrca = 1'b1;
                    alusrcb = 2'b10;
                end
                MEMRD:   iord = 1'b1;
                MEMWB: begin
                    memtoreg = 1'b1;
                    regwrite = 1'b1;
                end
                MEMWR: begin
                    iord     = 1'b1;
                    memwrite = 1'b1;
                end
                RTYPEEX: begin
                    alusrca = 1'b1;
                    aluop   = 2'b10;
                end
                RTYPEWB: begin
                    regdst   = 1'b1;
                    regwrite = 1'b1;
                end
                BEQEX: begin
                    alusrca = 1'b1;
                    aluop   = 2'b01;
                    pcsrc   = 2'b01;
                    branch  = 1'b1;
                end
                ADDIEX: begin
                    alusrca = 1'b1;
                    alusrcb = 2'b10;
                end
                ADDIWB:  regwrite = 1'b1;
`ifdef MC_MAINDEC_JUMP_EN
                JEX: begin
                    pcsrc   = 2'b10;
                    pcwrite = 1'b1;
                end
`endif
                ERROR:   illegal = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: doc/mc_maindec.md
# mc_maindec

Multicycle main controller FSM for the MIPS datapath. Sequences each instruction through fetch, decode, execute, memory and writeback. Drives all datapath enables and muxes, and produces the 2-bit `aluop` that the ALU decoder consumes alongside `funct`. It also stalls on a single-bit memory-ready handshake and traps illegal opcodes.

## Interface
Parameters: none.

Ports:
- `clk` in 1: sole clock; all state changes on rising edge.
- `reset` in 1: synchronous, active-high.
- `op` in 6: opcode field of the instruction register.
- `memready` in 1: memory completes the current access this cycle.
- `iord` out 1: memory address select (0 = PC, 1 = ALUOut).
- `memwrite` out 1: memory write strobe.
- `irwrite` out 1: instruction register load.
- `pcwrite` out 1: unconditional PC load.
- `branch` out 1: PC load if ALU zero.
- `pcsrc` out 2: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `alusrca` out 1: 0 = PC, 1 = register A.
- `alusrcb` out 2: 00 = register B, 01 = constant 4, 10 = sign-extended immediate, 11 = immediate shifted left 2.
- `aluop` out 2: 00 = add, 01 = subtract, 10 = use `funct`.
- `regdst` out 1: 0 = rt, 1 = rd.
- `memtoreg` out 1: 0 = ALUOut, 1 = memory data.
- `regwrite` out 1: register file write.
- `illegal` out 1: sticky illegal-opcode flag.

## Operation
- Opcodes: `lw` 100011, `sw` 101011, R-type 000000, `beq` 000100, `addi` 001000, `j` 000010.
- Any output not listed for a state below is 0.
- States and outputs:
  - FETCH: `alusrcb`=01, `aluop`=00, `pcsrc`=00; `irwrite`=`pcwrite`=`memready`.
  - DECODE: `alusrcb`=11, `aluop`=00.
  - MEMADR: `alusrca`=1, `alusrcb`=10, `aluop`=00.
  - MEMRD: `iord`=1.
  - MEMWB: `memtoreg`=1, `regwrite`=1.
  - MEMWR: `iord`=1, `memwrite`=1.
  - RTYPEEX: `alusrca`=1, `alusrcb`=00, `aluop`=10.
  - RTYPEWB: `regdst`=1, `regwrite`=1.
  - BEQEX: `alusrca`=1, `aluop`=01, `pcsrc`=01, `branch`=1.
  - ADDIEX: `alusrca`=1, `alusrcb`=10, `aluop`=00.
  - ADDIWB: `regwrite`=1.
  - JEX: `pcsrc`=10, `pcwrite`=1.
  - ERROR: `illegal`=1.
- Transitions:
  - FETCH→DECODE only when `memready`=1; otherwise hold.
  - DECODE dispatches on `op`:
    - `lw`/`sw`→MEMADR
    - R-type→RTYPEEX
    - `beq`→BEQEX
    - `addi`→ADDIEX
    - `j`→JEX
    - any other→ERROR
  - MEMADR→MEMRD for `lw`, MEMWR for `sw`.
  - MEMRD→MEMWB on `memready`; otherwise hold.
  - MEMWR→FETCH on `memready`; otherwise hold, with `memwrite` held high throughout.
  - MEMWB, RTYPEWB, ADDIWB, BEQEX, JEX→FETCH.
  - RTYPEEX→RTYPEWB; ADDIEX→ADDIWB.
  - ERROR→ERROR until `reset`.
- `op` is sampled only in DECODE and MEMADR; it is stable there because `irwrite` is 0 outside FETCH.
- The FSM is Moore, except `irwrite`/`pcwrite` in FETCH, which combinationally follow `memready`.

## Timing
- Reset: while `reset`=1, every output is forced to 0, including `illegal`. The first rising edge with `reset`=1 loads FETCH.
- Reset asserted mid-instruction aborts it at the next edge; no writeback strobe is issued after that edge.
- Cycle counts with `memready` tied high, FETCH through the last state:
  - `lw` 5
  - `sw`, R-type, `addi` 4
  - `beq`, `j` 3
- Each cycle `memready`=0 in FETCH, MEMRD or MEMWR adds one cycle. `memready` in any other state is ignored.
- `memready` and `reset` both high: reset wins.

## Configuration
- `MC_MAINDEC_JUMP_EN`:
  - Defined: `j` decodes to JEX.
  - Undefined: JEX does not exist, and opcode 000010 takes DECODE→ERROR like any illegal opcode.

## Test plan
- Reset and fetch: hold `reset` for 2 cycles with `memready`=1 → all outputs 0 during reset. First cycle after release is FETCH with `irwrite`=`pcwrite`=1, `alusrcb`=01, `aluop`=00.
- `lw` with wait: `op`=100011; drive `memready`=0 for 2 cycles in MEMRD → states FETCH, DECODE, MEMADR, MEMRD×3, MEMWB (7 cycles). `regwrite`=`memtoreg`=1 only in MEMWB.
- R-type then `beq`, `memready`=1:
  - R-type: `aluop`=10 in RTYPEEX; `regdst`=`regwrite`=1 the next cycle.
  - `beq`: `aluop`=01, `branch`=1, `pcsrc`=01, then back to FETCH.
- `sw` stall: `op`=101011, `memready`=0 for 3 cycles in MEMWR → `memwrite`=1 for all 4 MEMWR cycles, `iord`=1, then FETCH.
- Illegal opcode: `op`=111111 → `illegal`=1 from the cycle after DECODE and held for 10 cycles. No `regwrite`, `pcwrite` or `memwrite` occurs; `reset` clears it.
- `j` (run with and without `MC_MAINDEC_JUMP_EN`), `op`=000010:
  - Defined: `pcsrc`=10, `pcwrite`=1 in JEX, 3-cycle instruction.
  - Undefined: `illegal`=1.
